// File: rtl/hpu_pkg.sv
// Shared constants and the beat record used by the result packer and its FIFO.
package hpu_pkg;

  localparam int AXIS_DATA_W = 64;
  localparam int RES_W       = 32;
  localparam int STRB_W      = AXIS_DATA_W / 8;

  localparam logic [STRB_W-1:0] STRB_FULL = 8'hff;
  localparam logic [STRB_W-1:0] STRB_LO   = 8'h0f;

  // One FIFO entry: 64 data bits, 8 strobe bits, last flag (73 bits total).
  typedef struct packed {
    logic [AXIS_DATA_W-1:0] data;
    logic [STRB_W-1:0]      strb;
    logic                   last;
  } beat_t;

  localparam int BEAT_W = $bits(beat_t);

endpackage

// File: rtl/beat_fifo.sv
// Synchronous FIFO with registered count, simultaneous push/pop and a synchronous clear.
// The read port shows the head entry and reads as zero while the FIFO is empty.
module beat_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 73
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign full    = (r_count == (AW+1)'(DEPTH));
  assign empty   = (r_count == '0);
  assign w_push  = push & ~full;
  assign w_pop   = pop & ~empty;
  assign rd_data = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; entries are only visible once counted in.
  always_ff @(posedge clk) begin
    if (w_push && !clear) r_mem[r_wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/result_packer.sv
// Pairs 32-bit result words into 64-bit AXI-Stream beats, marks packet ends with TLAST
// and buffers beats so that sink backpressure stalls the producer.
module result_packer
  import hpu_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic                   AXIS_ACLK,
  input  logic                   AXIS_ARESETN,
  input  logic                   run,
  input  logic [CNT_W-1:0]       pkt_words,
  input  logic                   res_valid,
  input  logic [RES_W-1:0]       res_data,
  output logic                   res_ready,
  output logic                   M_AXIS_TVALID,
  output logic [AXIS_DATA_W-1:0] M_AXIS_TDATA,
  output logic [STRB_W-1:0]      M_AXIS_TSTRB,
  output logic                   M_AXIS_TLAST,
  input  logic                   M_AXIS_TREADY,
  output logic                   busy
);

  logic [CNT_W-1:0] r_wcnt;
  logic [RES_W-1:0] r_lo;
  logic             r_half;
  logic             r_active;

  logic [CNT_W-1:0] w_last_idx;
  logic             w_is_last;
  logic             w_odd;
  logic             w_accept;
  logic             w_push;
  logic             w_full;
  logic             w_empty;
  beat_t            w_beat;
  beat_t            w_head;

  // pkt_words of zero behaves as a one-word packet.
  assign w_last_idx = (pkt_words == '0) ? '0 : pkt_words - 1'b1;
  assign w_is_last  = (r_wcnt == w_last_idx);
  assign w_odd      = r_wcnt[0];

  // r_active keeps res_ready low while reset is held and until the first edge after release.
  assign res_ready = run & r_active & ~w_full;
  assign w_accept  = res_valid & res_ready;
  assign w_push    = w_accept & (w_odd | w_is_last);

  always_comb begin
    w_beat.data = {res_data, r_lo};
    w_beat.strb = STRB_FULL;
    w_beat.last = w_is_last;
    if (!w_odd) begin
      w_beat.data = {{RES_W{1'b0}}, res_data};
      w_beat.strb = STRB_LO;
    end
  end

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      r_wcnt   <= '0;
      r_lo     <= '0;
      r_half   <= 1'b0;
      r_active <= 1'b0;
    end else begin
      r_active <= 1'b1;
      if (!run) begin
        r_wcnt <= '0;
        r_half <= 1'b0;
      end else if (w_accept) begin
        r_wcnt <= w_is_last ? '0 : r_wcnt + 1'b1;
        if (!w_odd && !w_is_last) begin
          r_lo   <= res_data;
          r_half <= 1'b1;
        end else begin
          r_half <= 1'b0;
        end
      end
    end
  end

  beat_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BEAT_W)
  ) u_fifo (
    .clk     (AXIS_ACLK),
    .rst_n   (AXIS_ARESETN),
    .clear   (~run),
    .push    (w_push),
    .pop     (M_AXIS_TREADY),
    .wr_data (w_beat),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty)
  );

  assign M_AXIS_TVALID = ~w_empty;
  assign M_AXIS_TDATA  = w_head.data;
  assign M_AXIS_TSTRB  = w_head.strb;
  assign M_AXIS_TLAST  = w_head.last;
  assign busy          = ~w_empty | r_half;

endmodule

// File: tb/tb_result_packer.sv
// Scoreboard bench for result_packer: a word-level model predicts every beat as words are
// accepted, and each scenario task compares the beats the sink actually takes.
module tb_result_packer;
  import hpu_pkg::*;

  localparam int DEPTH = 8;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          rstN;
  logic          run;
  logic [CW-1:0] pktWords;
  logic          resValid;
  logic [31:0]   resData;
  logic          resReady;
  logic          tvalid;
  logic [63:0]   tdata;
  logic [7:0]    tstrb;
  logic          tlast;
  logic          tready;
  logic          busy;

  always #5 clk = ~clk;

  result_packer #(
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (CW)
  ) dut (
    .AXIS_ACLK     (clk),
    .AXIS_ARESETN  (rstN),
    .run           (run),
    .pkt_words     (pktWords),
    .res_valid     (resValid),
    .res_data      (resData),
    .res_ready     (resReady),
    .M_AXIS_TVALID (tvalid),
    .M_AXIS_TDATA  (tdata),
    .M_AXIS_TSTRB  (tstrb),
    .M_AXIS_TLAST  (tlast),
    .M_AXIS_TREADY (tready),
    .busy          (busy)
  );

  int    checks   = 0;
  int    failures = 0;
  beat_t sbq[$];
  beat_t expBeat;
  int    mWcnt = 0;
  logic [31:0] mLo = '0;

  logic        obsValid, obsLast, obsReady, obsBusy, obsAccept, obsPop;
  logic [63:0] obsData;
  logic [7:0]  obsStrb;

  // Word-level reference: pair words, close the packet on the last word.
  task automatic modelAccept(input logic [31:0] d);
    int    lastIdx = (pktWords == 0) ? 0 : int'(pktWords) - 1;
    beat_t b;
    if (mWcnt == lastIdx) begin
      if (mWcnt % 2 == 1) begin
        b.data = {d, mLo};
        b.strb = 8'hff;
      end else begin
        b.data = {32'h0, d};
        b.strb = 8'h0f;
      end
      b.last = 1'b1;
      sbq.push_back(b);
      mWcnt = 0;
    end else if (mWcnt % 2 == 1) begin
      b.data = {d, mLo};
      b.strb = 8'hff;
      b.last = 1'b0;
      sbq.push_back(b);
      mWcnt++;
    end else begin
      mLo = d;
      mWcnt++;
    end
  endtask

  // Drive one cycle on the falling edge and sample what the next rising edge will see.
  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic tr, input logic rn);
    @(negedge clk);
    resValid = v;
    resData  = d;
    tready   = tr;
    run      = rn;
    #1;
    obsValid  = tvalid;
    obsData   = tdata;
    obsStrb   = tstrb;
    obsLast   = tlast;
    obsReady  = resReady;
    obsBusy   = busy;
    obsAccept = v & resReady;
    obsPop    = tvalid & tr & rn;
    if (obsAccept) modelAccept(d);
    if (!rn) begin
      sbq.delete();
      mWcnt = 0;
    end
  endtask

  task automatic setPacket(input logic [CW-1:0] pw);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    pktWords = pw;
  endtask

  task automatic test_reset();
    rstN     = 1'b0;
    run      = 1'b1;
    pktWords = 16'd8;
    resValid = 1'b0;
    resData  = '0;
    tready   = 1'b1;
    #3;
    checks += 6;
    if (tvalid !== 1'b0) begin failures++; $display("[TB] FAIL reset_tvalid: got %b required 0", tvalid); end
    if (tdata !== 64'h0) begin failures++; $display("[TB] FAIL reset_tdata: got %h required 0", tdata); end
    if (tstrb !== 8'h0) begin failures++; $display("[TB] FAIL reset_tstrb: got %h required 0", tstrb); end
    if (tlast !== 1'b0) begin failures++; $display("[TB] FAIL reset_tlast: got %b required 0", tlast); end
    if (resReady !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready: got %b required 0", resReady); end
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b required 0", busy); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checks++;
    if (obsReady !== 1'b1) begin failures++; $display("[TB] FAIL reset_release_ready: got %b required 1", obsReady); end
  endtask

  task automatic test_full_packet();
    int idx = 0;
    int acc2 = -1;
    setPacket(16'd8);
    for (int c = 0; c < 100 && (idx < 8 || sbq.size() != 0); c++) begin
      applyStimulus(idx < 8, 32'(idx + 1), 1'b1, 1'b1);
      if (c == acc2) begin
        checks++;
        if (obsValid !== 1'b0) begin failures++; $display("[TB] FAIL latency_early: tvalid %b required 0", obsValid); end
      end
      if (acc2 >= 0 && c == acc2 + 1) begin
        checks++;
        if (obsValid !== 1'b1) begin failures++; $display("[TB] FAIL latency_beat: tvalid %b required 1", obsValid); end
      end
      if (obsPop) begin
        checks++;
        if (sbq.size() == 0) begin
          failures++; $display("[TB] FAIL full_pop: got beat %h, required none", obsData);
        end else begin
          expBeat = sbq.pop_front();
          if (obsData !== expBeat.data || obsStrb !== expBeat.strb || obsLast !== expBeat.last) begin
            failures++;
            $display("[TB] FAIL full_beat: got %h/%h/%b required %h/%h/%b", obsData, obsStrb, obsLast, expBeat.data, expBeat.strb, expBeat.last);
          end
        end
      end
      if (obsAccept) begin
        if (idx == 1) acc2 = c;
        idx++;
      end
    end
    checks++;
    if (idx < 8 || sbq.size() != 0) begin failures++; $display("[TB] FAIL full_timeout: sent %0d pending %0d required 8/0", idx, sbq.size()); end
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checks++;
    if (obsValid !== 1'b0 || obsBusy !== 1'b0) begin failures++; $display("[TB] FAIL full_idle: tvalid %b busy %b required 0 0", obsValid, obsBusy); end
  endtask

  task automatic test_odd_packet();
    logic [31:0] words [5] = '{32'hA0000001, 32'hB0000002, 32'hC0000003, 32'hD0000004, 32'hE0000005};
    int idx = 0;
    int pops = 0;
    setPacket(16'd3);
    for (int c = 0; c < 100 && (idx < 5 || sbq.size() != 0); c++) begin
      applyStimulus(idx < 5, (idx < 5) ? words[idx] : 32'h0, 1'b1, 1'b1);
      if (obsPop) begin
        checks++;
        if (sbq.size() == 0) begin
          failures++; $display("[TB] FAIL odd_pop: got beat %h, required none", obsData);
        end else begin
          expBeat = sbq.pop_front();
          if (obsData !== expBeat.data || obsStrb !== expBeat.strb || obsLast !== expBeat.last) begin
            failures++;
            $display("[TB] FAIL odd_beat: got %h/%h/%b required %h/%h/%b", obsData, obsStrb, obsLast, expBeat.data, expBeat.strb, expBeat.last);
          end
        end
        pops++;
      end
      if (obsAccept) idx++;
    end
    checks++;
    if (idx < 5 || sbq.size() != 0 || pops != 3) begin failures++; $display("[TB] FAIL odd_count: beats %0d pending %0d required 3/0", pops, sbq.size()); end
  endtask

  task automatic test_backpressure();
    int idx = 0;
    int pops = 0;
    setPacket(16'd8);
    for (int c = 0; c < 20; c++) begin
      applyStimulus(1'b1, 32'h100 + 32'(idx), 1'b0, 1'b1);
      if (obsAccept) idx++;
    end
    checks += 3;
    if (idx != 16) begin failures++; $display("[TB] FAIL bp_accepted: got %0d required 16", idx); end
    if (obsReady !== 1'b0) begin failures++; $display("[TB] FAIL bp_ready: got %b required 0", obsReady); end
    if (obsBusy !== 1'b1) begin failures++; $display("[TB] FAIL bp_busy: got %b required 1", obsBusy); end
    for (int c = 0; c < 200 && (idx < 20 || sbq.size() != 0); c++) begin
      applyStimulus(idx < 20, 32'h100 + 32'(idx), 1'b1, 1'b1);
      if (obsPop) begin
        checks++;
        if (sbq.size() == 0) begin
          failures++; $display("[TB] FAIL bp_pop: got beat %h, required none", obsData);
        end else begin
          expBeat = sbq.pop_front();
          if (obsData !== expBeat.data || obsStrb !== expBeat.strb || obsLast !== expBeat.last) begin
            failures++;
            $display("[TB] FAIL bp_beat: got %h/%h/%b required %h/%h/%b", obsData, obsStrb, obsLast, expBeat.data, expBeat.strb, expBeat.last);
          end
        end
        pops++;
      end
      if (obsAccept) idx++;
    end
    checks++;
    if (pops != 10 || sbq.size() != 0) begin failures++; $display("[TB] FAIL bp_count: beats %0d pending %0d required 10/0", pops, sbq.size()); end
  endtask

  task automatic test_toggle_ready();
    int          idx = 0;
    logic        prevStall = 1'b0;
    logic [72:0] prevBeat = '0;
    logic        tr;
    setPacket(16'd5);
    for (int c = 0; c < 300 && (idx < 30 || sbq.size() != 0); c++) begin
      tr = (c % 2 == 0);
      applyStimulus(idx < 30, 32'h5000 + 32'(idx), tr, 1'b1);
      if (prevStall) begin
        checks++;
        if (obsValid !== 1'b1 || {obsData, obsStrb, obsLast} !== prevBeat) begin
          failures++;
          $display("[TB] FAIL toggle_stable: got %b %h required 1 %h", obsValid, {obsData, obsStrb, obsLast}, prevBeat);
        end
      end
      prevStall = obsValid & ~tr;
      prevBeat  = {obsData, obsStrb, obsLast};
      if (obsPop) begin
        checks++;
        if (sbq.size() == 0) begin
          failures++; $display("[TB] FAIL toggle_pop: got beat %h, required none", obsData);
        end else begin
          expBeat = sbq.pop_front();
          if (obsData !== expBeat.data || obsStrb !== expBeat.strb || obsLast !== expBeat.last) begin
            failures++;
            $display("[TB] FAIL toggle_beat: got %h/%h/%b required %h/%h/%b", obsData, obsStrb, obsLast, expBeat.data, expBeat.strb, expBeat.last);
          end
        end
      end
      if (obsAccept) idx++;
    end
    checks++;
    if (idx < 30 || sbq.size() != 0) begin failures++; $display("[TB] FAIL toggle_timeout: sent %0d pending %0d required 30/0", idx, sbq.size()); end
  endtask

  task automatic test_run_abort();
    int          idx = 0;
    logic        firstSeen = 1'b0;
    logic [63:0] firstData = '0;
    setPacket(16'd8);
    for (int c = 0; c < 50 && idx < 7; c++) begin
      applyStimulus(1'b1, 32'h700 + 32'(idx), 1'b0, 1'b1);
      if (obsAccept) idx++;
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checks++;
    if (obsBusy !== 1'b1 || obsValid !== 1'b1) begin failures++; $display("[TB] FAIL abort_pre: busy %b tvalid %b required 1 1", obsBusy, obsValid); end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checks += 2;
    if (obsValid !== 1'b0 || obsData !== 64'h0) begin failures++; $display("[TB] FAIL abort_tvalid: tvalid %b tdata %h required 0 0", obsValid, obsData); end
    if (obsBusy !== 1'b0) begin failures++; $display("[TB] FAIL abort_busy: got %b required 0", obsBusy); end
    idx = 0;
    for (int c = 0; c < 50 && (idx < 2 || sbq.size() != 0); c++) begin
      applyStimulus(idx < 2, 32'hA1 + 32'(idx), 1'b1, 1'b1);
      if (obsPop) begin
        checks++;
        if (sbq.size() == 0) begin
          failures++; $display("[TB] FAIL abort_pop: got beat %h, required none", obsData);
        end else begin
          expBeat = sbq.pop_front();
          if (obsData !== expBeat.data || obsStrb !== expBeat.strb || obsLast !== expBeat.last) begin
            failures++;
            $display("[TB] FAIL abort_beat: got %h/%h/%b required %h/%h/%b", obsData, obsStrb, obsLast, expBeat.data, expBeat.strb, expBeat.last);
          end
        end
        if (!firstSeen) firstData = obsData;
        firstSeen = 1'b1;
      end
      if (obsAccept) idx++;
    end
    checks++;
    if (firstData !== 64'h000000A2_000000A1) begin failures++; $display("[TB] FAIL abort_restart: got %h required 000000a2000000a1", firstData); end
  endtask

  task automatic test_async_reset();
    int idx = 0;
    setPacket(16'd8);
    for (int c = 0; c < 50 && idx < 5; c++) begin
      applyStimulus(1'b1, 32'h900 + 32'(idx), 1'b0, 1'b1);
      if (obsAccept) idx++;
    end
    #2 rstN = 1'b0;
    #1;
    checks += 3;
    if (tvalid !== 1'b0 || tdata !== 64'h0 || tstrb !== 8'h0 || tlast !== 1'b0) begin
      failures++; $display("[TB] FAIL areset_beat: got %b %h %h %b required all 0", tvalid, tdata, tstrb, tlast);
    end
    if (resReady !== 1'b0) begin failures++; $display("[TB] FAIL areset_ready: got %b required 0", resReady); end
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL areset_busy: got %b required 0", busy); end
    sbq.delete();
    mWcnt = 0;
    resValid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;
    idx = 0;
    for (int c = 0; c < 50 && (idx < 4 || sbq.size() != 0); c++) begin
      applyStimulus(idx < 4, 32'hB00 + 32'(idx), 1'b1, 1'b1);
      if (obsPop) begin
        checks++;
        if (sbq.size() == 0) begin
          failures++; $display("[TB] FAIL areset_pop: got beat %h, required none", obsData);
        end else begin
          expBeat = sbq.pop_front();
          if (obsData !== expBeat.data || obsStrb !== expBeat.strb || obsLast !== expBeat.last) begin
            failures++;
            $display("[TB] FAIL areset_resume: got %h/%h/%b required %h/%h/%b", obsData, obsStrb, obsLast, expBeat.data, expBeat.strb, expBeat.last);
          end
        end
      end
      if (obsAccept) idx++;
    end
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checks++;
    if (idx < 4 || sbq.size() != 0 || obsBusy !== 1'b0) begin
      failures++; $display("[TB] FAIL areset_drain: sent %0d pending %0d busy %b required 4/0/0", idx, sbq.size(), obsBusy);
    end
  endtask

  initial begin
    test_reset();
    test_full_packet();
    test_odd_packet();
    test_backpressure();
    test_toggle_ready();
    test_run_abort();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
